// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: default widths, BTB counter
// encodings and the saturating-counter update.
package fetch_unit_pkg;

  localparam int DEFAULT_PC_W    = 12;
  localparam int DEFAULT_BTB_IDX = 4;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  function automatic ctr_e ctr_next(input ctr_e ctr, input logic taken);
    ctr_e res;
    case (ctr)
      SNT:     res = taken ? WNT : SNT;
      WNT:     res = taken ? WT  : SNT;
      WT:      res = taken ? ST  : WNT;
      default: res = taken ? ST  : WT;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: stall pair, instruction memory, EX resolve/redirect and
// the IF/ID pipeline register outputs.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = DEFAULT_PC_W
);
  logic            go_one;
  logic            go_two;
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic            resolve_valid;
  logic [PC_W-1:0] resolve_pc;
  logic            resolve_taken;
  logic [PC_W-1:0] resolve_target;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic [PC_W-1:0] pc_4;
  logic [31:0]     instruction;
  logic [PC_W-1:0] addr;
  logic            p;
  logic            if_id_clear;

  modport master (
    input  go_one, go_two, imem_data,
    input  resolve_valid, resolve_pc, resolve_taken, resolve_target,
    input  redirect, redirect_pc,
    output imem_addr, pc_4, instruction, addr, p, if_id_clear
  );

  modport slave (
    output go_one, go_two, imem_data,
    output resolve_valid, resolve_pc, resolve_taken, resolve_target,
    output redirect, redirect_pc,
    input  imem_addr, pc_4, instruction, addr, p, if_id_clear
  );
endinterface

// File: rtl/fetch_btb.sv
// Direct-mapped branch target buffer with 2-bit counters: combinational
// lookup, synchronous update (lookup sees the pre-update entry).
module fetch_btb
  import fetch_unit_pkg::*;
#(
  parameter int PC_W    = DEFAULT_PC_W,
  parameter int BTB_IDX = DEFAULT_BTB_IDX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] lookup_pc_i,
  output logic            lookup_taken_o,
  output logic [PC_W-1:0] lookup_target_o,
  input  logic            upd_valid_i,
  input  logic [PC_W-1:0] upd_pc_i,
  input  logic            upd_taken_i,
  input  logic [PC_W-1:0] upd_target_i
);
  localparam int ENTRIES = 1 << BTB_IDX;
  localparam int TAG_W   = PC_W - BTB_IDX - 2;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [PC_W-1:0]    target_q [ENTRIES];
  ctr_e               ctr_q    [ENTRIES];

  logic [BTB_IDX-1:0] l_idx, u_idx;
  logic [TAG_W-1:0]   l_tag, u_tag;
  logic               l_hit, u_hit;
  logic               unused_lo;

  assign l_idx = lookup_pc_i[BTB_IDX+1:2];
  assign l_tag = lookup_pc_i[PC_W-1:BTB_IDX+2];
  assign u_idx = upd_pc_i[BTB_IDX+1:2];
  assign u_tag = upd_pc_i[PC_W-1:BTB_IDX+2];
  assign unused_lo = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign lookup_taken_o  = l_hit && ((ctr_q[l_idx] == WT) || (ctr_q[l_idx] == ST));
  assign lookup_target_o = target_q[l_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_valid_i && upd_taken_i) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // Payload arrays are not reset; valid_q alone gates their use.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid_i) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_next(ctr_q[u_idx], upd_taken_i);
        if (upd_taken_i) begin
          target_q[u_idx] <= upd_target_i;
        end
      end else if (upd_taken_i) begin
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= upd_target_i;
        ctr_q[u_idx]    <= WT;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BTB-predicted next-PC mux and the
// IF/ID-facing outputs.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = DEFAULT_PC_W,
  parameter int              BTB_IDX  = DEFAULT_BTB_IDX,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pc_4_w;
  logic [PC_W-1:0] pred_target;
  logic [PC_W-1:0] next_addr;
  logic            pred_taken;

  fetch_btb #(
    .PC_W    (PC_W),
    .BTB_IDX (BTB_IDX)
  ) u_btb (
    .clk             (clk),
    .rst             (rst),
    .lookup_pc_i     (pc_q),
    .lookup_taken_o  (pred_taken),
    .lookup_target_o (pred_target),
    .upd_valid_i     (bus.resolve_valid),
    .upd_pc_i        (bus.resolve_pc),
    .upd_taken_i     (bus.resolve_taken),
    .upd_target_i    (bus.resolve_target)
  );

  assign pc_4_w    = pc_q + PC_W'(4);
  assign next_addr = pred_taken ? pred_target : pc_4_w;

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = bus.redirect_pc;
    end else if (bus.go_one && bus.go_two) begin
      pc_d = next_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.pc_4        = pc_4_w;
  assign bus.instruction = bus.imem_data;
  assign bus.addr        = next_addr;
  assign bus.p           = pred_taken;
  assign bus.if_id_clear = bus.redirect;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed scenarios plus random traffic,
// checked against an integer-arithmetic model of the PC and BTB.
module tb_fetch_unit;

  localparam int RESET_PC = 0;

  typedef struct {
    int pc;
    int pc4;
    int addr;
    bit p;
    bit clr;
    logic [31:0] ins;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if #(.PC_W(12)) bus ();

  fetch_unit #(
    .PC_W     (12),
    .BTB_IDX  (4),
    .RESET_PC (12'h000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] imem_fn(input logic [11:0] a);
    return {a ^ 12'h5A5, 8'hC3, a};
  endfunction

  assign bus.imem_data = imem_fn(bus.imem_addr);

  // Reference model: PC plus 16 BTB entries, counters as integers 0..3.
  int m_pc;
  bit m_v   [16];
  int m_tag [16];
  int m_tgt [16];
  int m_cnt [16];

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   check_en = 0;

  task automatic predict(output bit pp, output int na);
    int idx;
    idx = (m_pc >> 2) & 15;
    pp  = m_v[idx] && (m_tag[idx] == ((m_pc >> 6) & 63)) && (m_cnt[idx] >= 2);
    na  = pp ? m_tgt[idx] : ((m_pc + 4) & 'hFFF);
  endtask

  task automatic model_step(input bit r, input bit go, input bit rv, input int rpc,
                            input bit rt, input int rtgt, input bit rd, input int rdpc,
                            input int na);
    int idx, tg;
    if (r) begin
      m_pc = RESET_PC;
      foreach (m_v[i]) m_v[i] = 0;
    end else begin
      if (rd) m_pc = rdpc & 'hFFF;
      else if (go) m_pc = na;
      if (rv) begin
        idx = (rpc >> 2) & 15;
        tg  = (rpc >> 6) & 63;
        if (m_v[idx] && m_tag[idx] == tg) begin
          if (rt) begin
            m_cnt[idx] = (m_cnt[idx] == 3) ? 3 : m_cnt[idx] + 1;
            m_tgt[idx] = rtgt & 'hFFF;
          end else begin
            m_cnt[idx] = (m_cnt[idx] == 0) ? 0 : m_cnt[idx] - 1;
          end
        end else if (rt) begin
          m_v[idx]   = 1;
          m_tag[idx] = tg;
          m_tgt[idx] = rtgt & 'hFFF;
          m_cnt[idx] = 2;
        end
      end
    end
  endtask

  // One clock: drive inputs, queue the expected outputs, advance the model.
  task automatic cycle(input bit r, input bit g1, input bit g2, input bit rv,
                       input int rpc, input bit rt, input int rtgt,
                       input bit rd, input int rdpc);
    bit   pp;
    int   na;
    exp_t e;
    rst                = r;
    bus.go_one         = g1;
    bus.go_two         = g2;
    bus.resolve_valid  = rv;
    bus.resolve_pc     = 12'(rpc);
    bus.resolve_taken  = rt;
    bus.resolve_target = 12'(rtgt);
    bus.redirect       = rd;
    bus.redirect_pc    = 12'(rdpc);
    predict(pp, na);
    if (check_en) begin
      e.pc   = m_pc;
      e.pc4  = (m_pc + 4) & 'hFFF;
      e.addr = na;
      e.p    = pp;
      e.clr  = rd;
      e.ins  = imem_fn(12'(m_pc));
      sb.push_back(e);
    end
    @(posedge clk);
    model_step(r, g1 && g2, rv, rpc, rt, rtgt, rd, rdpc, na);
    #1;
  endtask

  task automatic step(input bit g1, input bit g2);
    cycle(0, g1, g2, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resolve(input bit g1, input bit g2, input int pc, input bit t, input int tgt);
    cycle(0, g1, g2, 1, pc, t, tgt, 0, 0);
  endtask

  task automatic redir(input bit g1, input bit g2, input int pc);
    cycle(0, g1, g2, 0, 0, 0, 0, 1, pc);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("imem_addr",   32'(bus.imem_addr),   32'(e.pc));
      chk("pc_4",        32'(bus.pc_4),        32'(e.pc4));
      chk("addr",        32'(bus.addr),        32'(e.addr));
      chk("p",           32'(bus.p),           32'(e.p));
      chk("if_id_clear", 32'(bus.if_id_clear), 32'(e.clr));
      chk("instruction", bus.instruction,      e.ins);
    end
  end

  int pool [8] = '{'h020, 'h040, 'h080, 'h400, 'hFFC, 'h010, 'h03C, 'h104};

  initial begin
    bit r, g1, g2, rv, rt, rd;
    int rpc, rtgt, rdpc;

    m_pc = RESET_PC;
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
    check_en = 1;
    cycle(1, 1, 1, 0, 0, 0, 0, 0, 0);

    // Free run from reset, then a three-cycle stall at 0x010.
    repeat (4) step(1, 1);
    repeat (3) step(1, 0);
    repeat (2) step(1, 1);

    // Allocate 0x020 -> 0x008 and fetch through it.
    resolve(1, 1, 'h020, 1, 'h008);
    repeat (3) step(1, 1);

    // Counter walk at a held PC of 0x020.
    redir(0, 0, 'h020);
    repeat (2) resolve(0, 0, 'h020, 0, 0);
    repeat (3) resolve(0, 0, 'h020, 1, 'h008);
    step(0, 0);
    step(1, 1);

    // Redirect while stalled, then wrap from 0xFFC.
    redir(0, 1, 'h100);
    step(1, 1);
    redir(1, 1, 'hFFC);
    repeat (2) step(1, 1);

    // Same-cycle lookup/update on one index, then tag replacement.
    redir(0, 0, 'h040);
    resolve(0, 0, 'h040, 1, 'h0A0);
    step(0, 0);
    step(1, 1);
    resolve(1, 1, 'h400, 1, 'h48C);
    redir(1, 1, 'h040);
    repeat (2) step(1, 1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r    = ($urandom_range(0, 99) == 0);
      g1   = ($urandom_range(0, 7) != 0);
      g2   = ($urandom_range(0, 7) != 0);
      rv   = ($urandom_range(0, 2) == 0);
      rpc  = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 7)] : $urandom_range(0, 1023) * 4;
      rt   = $urandom_range(0, 1);
      rtgt = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : $urandom_range(0, 1023) * 4;
      rd   = ($urandom_range(0, 15) == 0);
      rdpc = ($urandom_range(0, 1) != 0) ? pool[$urandom_range(0, 7)] : $urandom_range(0, 1023) * 4;
      cycle(r, g1, g2, rv, rpc, rt, rtgt, rd, rdpc);
    end

    step(0, 0);
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d expected=0 entries left", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that drives the IF/ID pipeline register: supplies pc_4, instruction, predicted next address (addr) and prediction bit (p).
- Holds the PC and a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Honours the same go_one/go_two stall pair as IF/ID and takes mispredict redirects and branch resolutions from EX.
- Drives the IF/ID clear on redirect.

Parameters:
- PC_W, 12, PC width in bits; byte address, word-aligned, bits [1:0] always 0.
- BTB_IDX, 4, log2 of BTB entries (16 entries); index = pc[BTB_IDX+1:2], tag = pc[PC_W-1:BTB_IDX+2].
- RESET_PC, 12'h000, PC value loaded on reset.

Ports:
- clk, in, 1, rising-edge clock.
- rst, in, 1, synchronous active-high reset.
- go_one, in, 1, stall input; advance only when go_one & go_two.
- go_two, in, 1, second stall input.
- imem_addr, out, PC_W, current PC to instruction memory (combinational-read memory).
- imem_data, in, 32, instruction at imem_addr, same cycle.
- resolve_valid, in, 1, EX resolved a branch/jump this cycle (single-cycle pulse per branch).
- resolve_pc, in, PC_W, PC of the resolved branch.
- resolve_taken, in, 1, actual direction.
- resolve_target, in, PC_W, actual taken target.
- redirect, in, 1, EX mispredict; fetch must restart at redirect_pc.
- redirect_pc, in, PC_W, corrected fetch address.
- pc_4, out, PC_W, PC+4 (mod 2^PC_W), to IF/ID.
- instruction, out, 32, equals imem_data, to IF/ID.
- addr, out, PC_W, predicted next PC, to IF/ID.
- p, out, 1, predicted taken, to IF/ID.
- if_id_clear, out, 1, equals redirect (combinational), to IF/ID clear.

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. On reset, PC <= RESET_PC and all BTB valid bits are cleared.
- After reset: imem_addr = RESET_PC, pc_4 = RESET_PC+4, p = 0, addr = RESET_PC+4, if_id_clear = redirect.
- Lookup (combinational from PC):
  - hit = valid[idx] & (tag[idx] == PC tag).
  - p = hit & ctr[idx][1].
  - addr = p ? target[idx] : pc_4.
- PC update priority at posedge: rst > redirect > (go_one & go_two) > hold.
  - redirect: PC <= redirect_pc, even when stalled.
  - go: PC <= addr.
  - hold: PC unchanged.
- Latency: a redirect at edge N puts redirect_pc on imem_addr in cycle N+1. IF/ID sees if_id_clear in the same cycle, so the wrong-path instruction is squashed.
- Arithmetic: pc_4 = PC + 4 truncated to PC_W; 12'hFFC wraps to 12'h000. No carry out.
- BTB update on resolve_valid at posedge, independent of go and redirect:
  - Tag hit: ctr saturating +1 if taken, else -1 (00 and 11 saturate). Target <= resolve_target when taken.
  - Miss and taken: allocate entry; valid=1, tag, target, ctr=2'b10 (weakly taken).
  - Miss and not taken: no change.
- Read-before-write: a lookup and an update to the same index in the same cycle see the old entry. The new value is visible next cycle.
- During a stall, an update may change p/addr for the held PC. This is allowed: IF/ID captures addr/p in the same cycle the PC advances to addr, so the two stay consistent.
- rst asserted mid-operation overrides redirect and resolve_valid in that cycle; no BTB update occurs.

Decomposition:
- Shared package holds:
  - PC_W default.
  - Counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
  - Function ctr_next(ctr, taken).
- One sub-module, fetch_btb:
  - Valid/tag/target/ctr arrays.
  - Combinational lookup port and synchronous update port.
- fetch_unit contains the PC register, next-PC mux and wiring.

Test Plan:
- Reset then free-run with go=1, empty BTB -> imem_addr 0x000, 0x004, 0x008...; p=0, addr=pc_4 every cycle.
- go_two=0 for 3 cycles at PC 0x010 -> imem_addr holds 0x010; resumes 0x014 after go_two=1.
- resolve_valid, pc=0x020, taken, target=0x008 (miss) -> entry ctr=10. Next fetch at 0x020 gives p=1, addr=0x008, next imem_addr=0x008.
- Two not-taken resolves at 0x020 -> ctr 10->01->00, p=0. Three more taken resolves -> 01, 10, 11, saturating at 11.
- redirect=1, redirect_pc=0x100 while go_one=0 -> if_id_clear=1 that cycle; imem_addr=0x100 next cycle.
- PC=0xFFC, no hit -> pc_4=0x000, next imem_addr=0x000. Same-cycle resolve and lookup on one index -> lookup shows old entry, new entry next cycle.
